// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-ported synchronous SRAM.
// Data port has priority; one access in flight at a time.
// Optional wait-state support is built when MEM_ARBITER_WAIT_STATES_EN is defined;
// otherwise the access timing is fixed at issue -> ack with read data passed through.
module mem_arbiter #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_m_access,
    input  logic [19:1] i_m_address,
    output logic        i_m_ack,
    output logic [15:0] i_m_data,
    input  logic        d_m_access,
    input  logic [19:1] d_m_address,
    input  logic        d_m_wr_en,
    input  logic [1:0]  d_m_bytesel,
    input  logic [15:0] d_m_data_in,
    output logic        d_m_ack,
    output logic [15:0] d_m_data_out,
    output logic        sram_cs,
    output logic        sram_we,
    output logic [19:1] sram_address,
    output logic [1:0]  sram_bytesel,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StAck   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        port_q, port_d;     // 1 = data port owns the access
    logic [19:1] addr_q, addr_d;
    logic        we_q, we_d;
    logic [1:0]  bs_q, bs_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rd_data;

`ifdef MEM_ARBITER_WAIT_STATES_EN
    logic [3:0]  ws;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] cap_q, cap_d;

    assign ws = 4'(WAIT_STATES);
`else
    logic unused_ws;

    assign unused_ws = ^(4'(WAIT_STATES));
`endif

    // Next-state: arbitration, latching the granted request, and access sequencing
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        addr_d  = addr_q;
        we_d    = we_q;
        bs_d    = bs_q;
        wdata_d = wdata_q;
`ifdef MEM_ARBITER_WAIT_STATES_EN
        cnt_d   = cnt_q;
        cap_d   = cap_q;
`endif
        case (state_q)
            StIdle: begin
                if (d_m_access) begin
                    state_d = StIssue;
                    port_d  = 1'b1;
                    addr_d  = d_m_address;
                    we_d    = d_m_wr_en;
                    bs_d    = d_m_bytesel;
                    wdata_d = d_m_data_in;
                end else if (i_m_access) begin
                    state_d = StIssue;
                    port_d  = 1'b0;
                    addr_d  = i_m_address;
                    we_d    = 1'b0;
                    bs_d    = 2'b11;
                    wdata_d = 16'h0;
                end
            end
            StIssue: begin
`ifdef MEM_ARBITER_WAIT_STATES_EN
                if (ws != 4'd0) begin
                    state_d = StWait;
                    cnt_d   = ws - 4'd1;
                end else begin
                    state_d = StAck;
                end
`else
                state_d = StAck;
`endif
            end
            StWait: begin
`ifdef MEM_ARBITER_WAIT_STATES_EN
                // SRAM data is valid only in the first wait cycle
                if (cnt_q == ws - 4'd1) begin
                    cap_d = sram_rdata;
                end
                if (cnt_q == 4'd0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
`else
                state_d = StIdle;
`endif
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and latched-request registers; reset abandons any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            port_q  <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            bs_q    <= 2'b00;
            wdata_q <= 16'h0;
`ifdef MEM_ARBITER_WAIT_STATES_EN
            cnt_q   <= 4'd0;
            cap_q   <= 16'h0;
`endif
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            bs_q    <= bs_d;
            wdata_q <= wdata_d;
`ifdef MEM_ARBITER_WAIT_STATES_EN
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
`endif
        end
    end

    // Outputs: SRAM strobes from the latched access, acks and zero-gated read data
    always_comb begin
`ifdef MEM_ARBITER_WAIT_STATES_EN
        rd_data = (ws == 4'd0) ? sram_rdata : cap_q;
`else
        rd_data = sram_rdata;
`endif
        sram_cs      = (state_q == StIssue);
        sram_we      = sram_cs & we_q;
        sram_address = addr_q;
        sram_bytesel = bs_q;
        sram_wdata   = wdata_q;
        i_m_ack      = (state_q == StAck) & ~port_q;
        d_m_ack      = (state_q == StAck) & port_q;
        i_m_data     = i_m_ack ? rd_data : 16'h0;
        d_m_data_out = d_m_ack ? rd_data : 16'h0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Wait states are exercised (WAIT_STATES=3) when
// MEM_ARBITER_WAIT_STATES_EN is defined; otherwise the fixed zero-wait timing is checked.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_WAIT_STATES_EN
    localparam int unsigned W = 3;
`else
    localparam int unsigned W = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        i_m_access;
    logic [19:1] i_m_address;
    logic        i_m_ack;
    logic [15:0] i_m_data;
    logic        d_m_access;
    logic [19:1] d_m_address;
    logic        d_m_wr_en;
    logic [1:0]  d_m_bytesel;
    logic [15:0] d_m_data_in;
    logic        d_m_ack;
    logic [15:0] d_m_data_out;
    logic        sram_cs;
    logic        sram_we;
    logic [19:1] sram_address;
    logic [1:0]  sram_bytesel;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.WAIT_STATES(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_m_access   (i_m_access),
        .i_m_address  (i_m_address),
        .i_m_ack      (i_m_ack),
        .i_m_data     (i_m_data),
        .d_m_access   (d_m_access),
        .d_m_address  (d_m_address),
        .d_m_wr_en    (d_m_wr_en),
        .d_m_bytesel  (d_m_bytesel),
        .d_m_data_in  (d_m_data_in),
        .d_m_ack      (d_m_ack),
        .d_m_data_out (d_m_data_out),
        .sram_cs      (sram_cs),
        .sram_we      (sram_we),
        .sram_address (sram_address),
        .sram_bytesel (sram_bytesel),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle G+2; runs the wait cycles, checks the ack cycle, drops the request
    // and checks the following idle cycle.
    task automatic finish_access(input bit is_data, input logic [15:0] exp,
                                 input bit chk_data, input string name);
        if (W > 0) begin
            total++;
            if ({i_m_ack, d_m_ack, sram_cs} !== 3'b000) begin
                bad++;
                $display("FAIL %s_wait_first: ack/cs got %b want 000", name,
                         {i_m_ack, d_m_ack, sram_cs});
            end
            for (int k = 0; k < int'(W); k++) begin
                tick();
                sram_rdata = ~exp;
                if (k < int'(W) - 1) begin
                    total++;
                    if ({i_m_ack, d_m_ack} !== 2'b00) begin
                        bad++;
                        $display("FAIL %s_wait_%0d: acks got %b want 00", name, k,
                                 {i_m_ack, d_m_ack});
                    end
                end
            end
        end
        total++;
        if ({i_m_ack, d_m_ack} !== {~is_data, is_data}) begin
            bad++;
            $display("FAIL %s_ack: {i,d} got %b want %b", name, {i_m_ack, d_m_ack},
                     {~is_data, is_data});
        end
        if (chk_data) begin
            total++;
            if ((is_data ? d_m_data_out : i_m_data) !== exp) begin
                bad++;
                $display("FAIL %s_data: got %h want %h", name,
                         is_data ? d_m_data_out : i_m_data, exp);
            end
        end
        if (is_data) d_m_access = 1'b0;
        else         i_m_access = 1'b0;
        tick();
        total++;
        if ({i_m_ack, d_m_ack, sram_cs, i_m_data, d_m_data_out} !== 35'h0) begin
            bad++;
            $display("FAIL %s_after: ack/cs/data got %h want 0", name,
                     {i_m_ack, d_m_ack, sram_cs, i_m_data, d_m_data_out});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        total++;
        if ({i_m_ack, d_m_ack, sram_cs, sram_we, sram_address, sram_bytesel, i_m_data,
             d_m_data_out, sram_wdata} !== 73'h0) begin
            bad++;
            $display("FAIL reset_outputs: got nonzero outputs, want all 0");
        end
        tick();
        reset = 1'b0;
        tick();
        total++;
        if ({i_m_ack, d_m_ack, sram_cs} !== 3'b000) begin
            bad++;
            $display("FAIL reset_idle: ack/cs got %b want 000", {i_m_ack, d_m_ack, sram_cs});
        end
    endtask

    // Instruction read; address changes the cycle after grant and must not leak through
    task automatic test_instr_read();
        i_m_access  = 1'b1;
        i_m_address = 19'h00100;
        sram_rdata  = 16'hBEEF;
        tick();
        total++;
        if ({sram_cs, sram_we, sram_bytesel, i_m_ack} !== 5'b10110) begin
            bad++;
            $display("FAIL ird_issue: cs,we,bs,ack got %b want 10110",
                     {sram_cs, sram_we, sram_bytesel, i_m_ack});
        end
        total++;
        if (sram_address !== 19'h00100) begin
            bad++;
            $display("FAIL ird_addr: got %h want 00100", sram_address);
        end
        i_m_address = 19'h00200;
        tick();
        finish_access(1'b0, 16'hBEEF, 1'b1, "ird");
    endtask

    task automatic test_write();
        d_m_access  = 1'b1;
        d_m_wr_en   = 1'b1;
        d_m_address = 19'h00030;
        d_m_bytesel = 2'b10;
        d_m_data_in = 16'h12AB;
        tick();
        total++;
        if ({sram_cs, sram_we, sram_bytesel} !== 4'b1110) begin
            bad++;
            $display("FAIL wr_issue: cs,we,bs got %b want 1110", {sram_cs, sram_we, sram_bytesel});
        end
        total++;
        if ({sram_address, sram_wdata} !== {19'h00030, 16'h12AB}) begin
            bad++;
            $display("FAIL wr_addr_data: got %h/%h want 00030/12ab", sram_address, sram_wdata);
        end
        d_m_wr_en   = 1'b0;
        d_m_data_in = 16'h0000;
        tick();
        total++;
        if ({sram_cs, sram_we} !== 2'b00) begin
            bad++;
            $display("FAIL wr_one_cycle: cs,we got %b want 00", {sram_cs, sram_we});
        end
        finish_access(1'b1, 16'h0, 1'b0, "wr");
    endtask

    // Simultaneous requests: data first, instruction granted in the idle cycle after d_m_ack
    task automatic test_priority();
        d_m_access  = 1'b1;
        d_m_wr_en   = 1'b0;
        d_m_address = 19'h00020;
        d_m_bytesel = 2'b11;
        i_m_access  = 1'b1;
        i_m_address = 19'h00040;
        sram_rdata  = 16'hCAFE;
        tick();
        total++;
        if ({sram_cs, sram_we, sram_address} !== {2'b10, 19'h00020}) begin
            bad++;
            $display("FAIL prio_data_first: cs,we,addr got %h want data addr 00020",
                     {sram_cs, sram_we, sram_address});
        end
        tick();
        finish_access(1'b1, 16'hCAFE, 1'b1, "prio_d");
        sram_rdata = 16'h5A5A;
        tick();
        total++;
        if ({sram_cs, sram_address, sram_bytesel} !== {1'b1, 19'h00040, 2'b11}) begin
            bad++;
            $display("FAIL prio_instr_issue: cs,addr,bs got %h want instr 00040",
                     {sram_cs, sram_address, sram_bytesel});
        end
        tick();
        finish_access(1'b0, 16'h5A5A, 1'b1, "prio_i");
    endtask

    // Request dropped right after grant still completes
    task automatic test_drop();
        i_m_access  = 1'b1;
        i_m_address = 19'h00055;
        sram_rdata  = 16'h0F0F;
        tick();
        i_m_access = 1'b0;
        total++;
        if ({sram_cs, sram_address} !== {1'b1, 19'h00055}) begin
            bad++;
            $display("FAIL drop_issue: cs,addr got %h want 1/00055", {sram_cs, sram_address});
        end
        tick();
        finish_access(1'b0, 16'h0F0F, 1'b1, "drop");
    endtask

    task automatic test_reset_mid();
        i_m_access  = 1'b1;
        i_m_address = 19'h00077;
        sram_rdata  = 16'h7777;
        tick();
        if (W > 0) tick();
        reset = 1'b1;
        #1;
        total++;
        if ({i_m_ack, d_m_ack, sram_cs, sram_we, sram_address, sram_bytesel, i_m_data,
             d_m_data_out} !== 57'h0) begin
            bad++;
            $display("FAIL rstmid_outputs: got nonzero outputs, want all 0");
        end
        i_m_access = 1'b0;
        tick();
        reset = 1'b0;
        for (int k = 0; k < int'(W) + 4; k++) begin
            tick();
            total++;
            if ({i_m_ack, d_m_ack, sram_cs} !== 3'b000) begin
                bad++;
                $display("FAIL rstmid_no_ack_%0d: ack/cs got %b want 000", k,
                         {i_m_ack, d_m_ack, sram_cs});
            end
        end
        d_m_access  = 1'b1;
        d_m_wr_en   = 1'b0;
        d_m_address = 19'h00099;
        d_m_bytesel = 2'b01;
        sram_rdata  = 16'h4321;
        tick();
        total++;
        if ({sram_cs, sram_address, sram_bytesel} !== {1'b1, 19'h00099, 2'b01}) begin
            bad++;
            $display("FAIL rstmid_next_issue: cs,addr,bs got %h want 1/00099/01",
                     {sram_cs, sram_address, sram_bytesel});
        end
        tick();
        finish_access(1'b1, 16'h4321, 1'b1, "rstmid_next");
    endtask

    initial begin
        reset       = 1'b1;
        i_m_access  = 1'b0;
        i_m_address = '0;
        d_m_access  = 1'b0;
        d_m_address = '0;
        d_m_wr_en   = 1'b0;
        d_m_bytesel = 2'b00;
        d_m_data_in = 16'h0;
        sram_rdata  = 16'h0;
        test_reset();
        test_instr_read();
        test_write();
        test_priority();
        test_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_STATES, default 0, extra response cycles per access, 4-bit range 0..15.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 i_m_access  in  1  instruction-port request, held until i_m_ack.
REQ-005 i_m_address  in  19  instruction word address [19:1].
REQ-006 i_m_ack  out  1  one-cycle instruction completion strobe.
REQ-007 i_m_data  out  16  instruction read data, valid only while i_m_ack=1.
REQ-008 d_m_access  in  1  data-port request, held until d_m_ack.
REQ-009 d_m_address  in  19  data word address [19:1].
REQ-010 d_m_wr_en  in  1  1=write, 0=read.
REQ-011 d_m_bytesel  in  2  byte enables, bit0=[7:0], bit1=[15:8].
REQ-012 d_m_data_in  in  16  write data.
REQ-013 d_m_ack  out  1  one-cycle data completion strobe.
REQ-014 d_m_data_out  out  16  read data, valid only while d_m_ack=1.
REQ-015 sram_cs  out  1  SRAM select, one cycle per access.
REQ-016 sram_we  out  1  SRAM write strobe, only with sram_cs.
REQ-017 sram_address  out  19  SRAM word address.
REQ-018 sram_bytesel  out  2  SRAM byte enables; 2'b11 for instruction reads.
REQ-019 sram_wdata  out  16  SRAM write data.
REQ-020 sram_rdata  in  16  SRAM read data, valid the cycle after sram_cs.

Function
REQ-021 States SHALL be IDLE, ISSUE, WAIT, ACK; one access in flight.
REQ-022 IDLE: d_m_access=1 grants data; else i_m_access=1 grants instruction; data wins simultaneous requests.
REQ-023 On grant, address, wr_en, bytesel, write data and port SHALL be latched; later requester input changes (address change, access drop) SHALL NOT affect the access.
REQ-024 ISSUE (cycle G+1): sram_cs=1 driven from latched values; sram_we=latched wr_en (data port only).
REQ-025 WAIT_STATES=0: ACK at G+2; read data = sram_rdata passed straight through.
REQ-026 WAIT_STATES=W>0: sram_rdata captured at G+2; WAIT counts W cycles; ACK at G+2+W with captured data.
REQ-027 ACK lasts exactly one cycle, asserts only the granted port's ack, then IDLE.
REQ-028 Requester may reassert the cycle after ack; new grant no earlier than that IDLE cycle; throughput one access per 3+W cycles.
REQ-029 Write ack SHALL follow the same latency as read; d_m_data_out is don't-care on write acks.
REQ-030 i_m_ack and d_m_ack SHALL never be high together.
REQ-031 Granted access SHALL always complete and ack, even if access dropped meanwhile.
REQ-032 Non-acked data outputs SHALL be 16'h0.

Reset
REQ-033 Reset: state IDLE, counter 0, all acks/sram_cs/sram_we 0, sram_address 0, sram_bytesel 0, data outputs 0.
REQ-034 Reset mid-access SHALL abandon it with no ack after deassertion; first post-reset grant needs a fresh request.

Configuration
REQ-035 Macro MEM_ARBITER_WAIT_STATES_EN defined: WAIT state, counter, read-capture register built, WAIT_STATES honoured.
REQ-036 Macro undefined: no WAIT state or counter, WAIT_STATES ignored, fixed REQ-025 timing.

Verification
REQ-037 WAIT_STATES=0, i_m_access at 0x00010, sram_rdata=16'hBEEF -> sram_cs at G+1, i_m_ack one cycle at G+2, i_m_data=16'hBEEF.
REQ-038 Both ports request same cycle, d_m_address=0x00020 read -> data acked first; instruction granted IDLE cycle after d_m_ack, acked 3 cycles later.
REQ-039 Data write 0x00030, bytesel 2'b10, data 16'h12AB -> sram_we=1, sram_bytesel=2'b10, sram_wdata=16'h12AB for one cycle; d_m_ack next cycle.
REQ-040 Macro defined, WAIT_STATES=3, instruction read -> ack at G+5; data equals sram_rdata sampled at G+2 though sram_rdata changes later.
REQ-041 i_m_address 0x00100 -> 0x00200 the cycle after grant -> sram_address=0x00100; single ack.
REQ-042 Reset during WAIT -> no ack, all outputs 0; next request served normally.
